// File: rtl/qeciphy_tx_controller.sv
// QECIPHY transmit link controller: lock wait, training, partner handshake, sticky fault reporting.
// Optional partner-wait timeout is compiled in with `define QECIPHY_TX_PARTNER_TIMEOUT_EN.
module qeciphy_tx_controller #(
  parameter int LOCK_TIMEOUT_CYCLES    = 1024,
  parameter int MIN_ALIGN_CYCLES       = 128,
  parameter int PARTNER_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       tx_locked_i,
  input  logic       rx_rdy_i,
  input  logic       tx_underflow_i,
  output logic       tx_enable_o,
  output logic       tx_align_o,
  output logic       tx_rdy_o,
  output logic       tx_fault_fatal_o,
  output logic [3:0] tx_error_code_o
);

  localparam int MAX_BASE = (LOCK_TIMEOUT_CYCLES > MIN_ALIGN_CYCLES) ? LOCK_TIMEOUT_CYCLES
                                                                     : MIN_ALIGN_CYCLES;
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
  localparam int MAX_CNT = (PARTNER_TIMEOUT_CYCLES > MAX_BASE) ? PARTNER_TIMEOUT_CYCLES : MAX_BASE;
`else
  // Partner timeout is unused here; the zero product keeps it out of the counter width.
  localparam int MAX_CNT = MAX_BASE + 0 * PARTNER_TIMEOUT_CYCLES;
`endif
  localparam int CW = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ALIGN_LAST = CW'(MIN_ALIGN_CYCLES - 1);
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
  localparam logic [CW-1:0] PARTNER_LAST = CW'(PARTNER_TIMEOUT_CYCLES - 1);
`endif

  localparam logic [3:0] ERR_NONE         = 4'h0;
  localparam logic [3:0] ERR_LOCK_TIMEOUT = 4'h1;
  localparam logic [3:0] ERR_LOCK_LOST    = 4'h2;
  localparam logic [3:0] ERR_UNDERFLOW    = 4'h3;
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
  localparam logic [3:0] ERR_PARTNER_TO   = 4'h4;
`endif

  typedef enum logic [2:0] {
    S_DISABLED, S_WAIT_LOCK, S_ALIGN, S_WAIT_PARTNER, S_READY, S_FAULT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= S_DISABLED;
      cnt_q            <= '0;
      err_q            <= ERR_NONE;
      tx_enable_o      <= 1'b0;
      tx_align_o       <= 1'b0;
      tx_rdy_o         <= 1'b0;
      tx_fault_fatal_o <= 1'b0;
      tx_error_code_o  <= ERR_NONE;
    end else begin
      // Outputs follow the state register by one cycle.
      tx_enable_o      <= state_q inside {S_WAIT_LOCK, S_ALIGN, S_WAIT_PARTNER, S_READY};
      tx_align_o       <= state_q inside {S_WAIT_LOCK, S_ALIGN, S_WAIT_PARTNER};
      tx_rdy_o         <= (state_q == S_READY);
      tx_fault_fatal_o <= (state_q == S_FAULT);
      tx_error_code_o  <= (state_q == S_FAULT) ? err_q : ERR_NONE;

      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;

      if (!enable_i) begin
        err_q <= ERR_NONE;
        if (state_q != S_DISABLED) begin
          state_q <= S_DISABLED;
          cnt_q   <= '0;
        end
      end else begin
        unique case (state_q)
          S_DISABLED: begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end
          S_WAIT_LOCK: begin
            if (tx_locked_i) begin
              state_q <= S_ALIGN;
              cnt_q   <= '0;
            end else if (cnt_q == LOCK_LAST) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_LOCK_TIMEOUT;
            end
          end
          S_ALIGN: begin
            if (!tx_locked_i) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_LOCK_LOST;
            end else if (cnt_q == ALIGN_LAST) begin
              state_q <= S_WAIT_PARTNER;
              cnt_q   <= '0;
            end
          end
          S_WAIT_PARTNER: begin
            if (!tx_locked_i) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_LOCK_LOST;
            end else if (rx_rdy_i) begin
              state_q <= S_READY;
              cnt_q   <= '0;
            end
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
            else if (cnt_q == PARTNER_LAST) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_PARTNER_TO;
            end
`endif
          end
          S_READY: begin
            // Lock loss outranks underflow; losing the partner only drops back to training.
            if (!tx_locked_i) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_LOCK_LOST;
            end else if (tx_underflow_i) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              err_q   <= ERR_UNDERFLOW;
            end else if (!rx_rdy_i) begin
              state_q <= S_WAIT_PARTNER;
              cnt_q   <= '0;
            end
          end
          S_FAULT: ;
          default: begin
            state_q <= S_DISABLED;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qeciphy_tx_controller.sv
// Directed bench for qeciphy_tx_controller: behavioural link model checked every cycle plus literal pins.
module tb_qeciphy_tx_controller;
  localparam int LOCK_T = 16;
  localparam int MIN_AL = 8;
  localparam int PART_T = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, locked = 1'b0, rx = 1'b0, uf = 1'b0;
  logic       o_en, o_al, o_rdy, o_fat;
  logic [3:0] o_code;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  qeciphy_tx_controller #(
    .LOCK_TIMEOUT_CYCLES(LOCK_T), .MIN_ALIGN_CYCLES(MIN_AL), .PARTNER_TIMEOUT_CYCLES(PART_T)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .tx_locked_i(locked), .rx_rdy_i(rx),
    .tx_underflow_i(uf), .tx_enable_o(o_en), .tx_align_o(o_al), .tx_rdy_o(o_rdy),
    .tx_fault_fatal_o(o_fat), .tx_error_code_o(o_code)
  );

  always #5 clk = ~clk;

  // Link model: phase names are plain ints, time in phase is an unbounded int.
  localparam int P_OFF = 0, P_LOCK = 1, P_TRAIN = 2, P_PARTNER = 3, P_UP = 4, P_DEAD = 5;
  int phase = P_OFF, spent = 0, fault_code = 0;
  logic [7:0] exp_vec = '0;

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    if (!rst_n) begin
      phase = P_OFF; spent = 0; fault_code = 0; exp_vec = '0;
    end else begin
      // What the outputs show now is what the link was doing during the previous cycle.
      exp_vec = {phase != P_OFF && phase != P_DEAD,
                 phase == P_LOCK || phase == P_TRAIN || phase == P_PARTNER,
                 phase == P_UP, phase == P_DEAD,
                 (phase == P_DEAD) ? 4'(fault_code) : 4'h0};
      nxt = phase;
      if (!en) begin
        nxt = P_OFF; fault_code = 0;
      end else begin
        case (phase)
          P_OFF:   nxt = P_LOCK;
          P_LOCK:  if (locked) nxt = P_TRAIN;
                   else if (spent + 1 >= LOCK_T) begin nxt = P_DEAD; fault_code = 1; end
          P_TRAIN: if (!locked) begin nxt = P_DEAD; fault_code = 2; end
                   else if (spent + 1 >= MIN_AL) nxt = P_PARTNER;
          P_PARTNER: begin
            if (!locked) begin nxt = P_DEAD; fault_code = 2; end
            else if (rx) nxt = P_UP;
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
            else if (spent + 1 >= PART_T) begin nxt = P_DEAD; fault_code = 4; end
`endif
          end
          P_UP:    if (!locked) begin nxt = P_DEAD; fault_code = 2; end
                   else if (uf) begin nxt = P_DEAD; fault_code = 3; end
                   else if (!rx) nxt = P_PARTNER;
          default: ;
        endcase
      end
      spent = (nxt == phase) ? spent + 1 : 0;
      phase = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if ({o_en, o_al, o_rdy, o_fat, o_code} !== exp_vec) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got en/al/rdy/fat/code=%b expected %b", $time,
                 {o_en, o_al, o_rdy, o_fat, o_code}, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic disable_link();
    en = 0; locked = 0; rx = 0; uf = 0;
    tick(16);
    chk("disabled_all_zero", {o_en, o_al, o_rdy, o_fat, o_code}, 8'h00);
  endtask

  // Enable with lock and rx already present: READY is entered on edge 2+MIN_AL+1.
  task automatic bring_up();
    en = 1; locked = 1; rx = 1;
    tick(MIN_AL + 5);
    chk("bring_up_rdy", {7'b0, o_rdy}, 8'h01);
  endtask

  initial begin
    tick(3);
    chk_on = 1;
    chk("reset_outputs", {o_en, o_al, o_rdy, o_fat, o_code}, 8'h00);
    rst_n = 1;

    // Nominal bring-up: enable before edge 1, lock before edge 5, rx before edge 20.
    en = 1;
    tick(1); chk("nom_en_c1", {7'b0, o_en}, 8'h00);
    tick(1); chk("nom_en_al_c2", {6'b0, o_en, o_al}, 8'h03);
    tick(2); locked = 1;
    tick(15); rx = 1;
    tick(1); chk("nom_rdy_c20", {7'b0, o_rdy}, 8'h00);
    tick(1); chk("nom_rdy_c21", {o_rdy, o_al, 2'b0, o_code}, 8'h80);

    // Partner drop returns to training without a fault.
    rx = 0; tick(2);
    chk("rxdrop_train", {o_rdy, o_al, o_fat, 5'b0}, 8'h40);
    rx = 1; tick(2);
    chk("rxrise_ready", {7'b0, o_rdy}, 8'h01);

    // Underflow alone.
    uf = 1; tick(1); uf = 0; tick(1);
    chk("underflow_code", {o_en, o_rdy, o_fat, 1'b0, o_code}, 8'h23);
    tick(5);
    chk("fault_sticky", {3'b0, o_fat, o_code}, 8'h13);
    disable_link();

    // Lock timeout: 16 cycles in WAIT_LOCK, fault visible on edge 18.
    en = 1;
    tick(17); chk("lto_before", {7'b0, o_fat}, 8'h00);
    tick(1);  chk("lto_fault", {o_en, 2'b0, o_fat, o_code}, 8'h11);
    disable_link();
    en = 1; tick(2);
    chk("reenable_wait_lock", {o_en, o_al, o_rdy, o_fat, o_code}, 8'hC0);

    // Lock loss during ALIGN.
    locked = 1; tick(3);
    locked = 0; tick(1); locked = 1; tick(1);
    chk("lockloss_align", {3'b0, o_fat, o_code}, 8'h12);
    disable_link();

    // Lock loss during READY.
    bring_up();
    locked = 0; tick(1); locked = 1; tick(1);
    chk("lockloss_ready", {o_rdy, 2'b0, o_fat, o_code}, 8'h12);
    disable_link();

    // Lock loss and underflow together: lock loss wins.
    bring_up();
    locked = 0; uf = 1; tick(1); locked = 1; uf = 0; tick(1);
    chk("lockloss_beats_uf", {3'b0, o_fat, o_code}, 8'h12);
    disable_link();

    // Partner never ready: WAIT_PARTNER entered on edge 2+MIN_AL.
    en = 1; locked = 1; rx = 0;
`ifdef QECIPHY_TX_PARTNER_TIMEOUT_EN
    tick(2 + MIN_AL + PART_T);
    chk("pto_before", {7'b0, o_fat}, 8'h00);
    tick(1);
    chk("pto_fault", {o_en, 2'b0, o_fat, o_code}, 8'h14);
`else
    tick(2 + MIN_AL + 1000);
    chk("partner_wait_forever", {o_en, o_al, o_rdy, o_fat, o_code}, 8'hC0);
`endif

    // Asynchronous reset mid-operation.
    rst_n = 0; #1;
    chk("async_reset", {o_en, o_al, o_rdy, o_fat, o_code}, 8'h00);
    tick(2); rst_n = 1;
    en = 0; locked = 0;
    tick(4);
    chk("post_reset_idle", {o_en, o_al, o_rdy, o_fat, o_code}, 8'h00);

    chk_on = 0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qeciphy_tx_controller.md
Name: qeciphy_tx_controller

Overview:
- Transmit-side link controller for the QECIPHY; the counterpart of the receive controller.
- Enables the transmit datapath, waits for transmit-path lock, and drives alignment/training words so the far-end receiver can lock.
- Holds training until the local receive controller reports ready, then raises tx_rdy_o for user traffic.
- Detects lock loss, lock timeout and data underflow; reports them as a sticky fatal fault with a 4-bit code.

Parameters:
- LOCK_TIMEOUT_CYCLES, 1024, max cycles in WAIT_LOCK before fault (>=2).
- MIN_ALIGN_CYCLES, 128, minimum uninterrupted training cycles after lock (>=1).
- PARTNER_TIMEOUT_CYCLES, 65536, max cycles in WAIT_PARTNER before fault (only with optional feature).

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  link enable; low for >=16 cycles whenever deasserted.
- tx_locked_i  in  1  transmit PLL/gearbox lock; meaningful only while tx_enable_o=1.
- rx_rdy_i  in  1  local receive controller ready (far end proven alive).
- tx_underflow_i  in  1  single-cycle pulse: transmit data FIFO underflow; meaningful only in READY.
- tx_enable_o  out  1  enables transmit datapath.
- tx_align_o  out  1  1 = transmit alignment/training words instead of user data.
- tx_rdy_o  out  1  link ready for user traffic.
- tx_fault_fatal_o  out  1  sticky fatal fault.
- tx_error_code_o  out  4  fault cause; 0 when no fault.

Behaviour:
- All outputs registered; derived from the state register. Asynchronous reset: state=DISABLED, counter=0, all outputs 0, tx_error_code_o=4'h0.
- States: DISABLED, WAIT_LOCK, ALIGN, WAIT_PARTNER, READY, FAULT.
- One shared cycle counter. Width = $clog2(max(all timeout params)+1). Cleared on every state entry. Saturates; never wraps.
- DISABLED:
  - all outputs 0.
  - enable_i=1 -> WAIT_LOCK.
- WAIT_LOCK:
  - tx_enable_o=1, tx_align_o=1.
  - tx_locked_i=1 -> ALIGN.
  - else counter reaches LOCK_TIMEOUT_CYCLES-1 -> FAULT, code 4'h1.
  - Lock arriving on the timeout cycle: lock wins.
- ALIGN:
  - tx_enable_o=1, tx_align_o=1.
  - tx_locked_i=0 -> FAULT, code 4'h2.
  - else after MIN_ALIGN_CYCLES cycles in ALIGN -> WAIT_PARTNER.
- WAIT_PARTNER:
  - tx_enable_o=1, tx_align_o=1.
  - tx_locked_i=0 -> FAULT, code 4'h2.
  - else rx_rdy_i=1 -> READY.
- READY:
  - tx_enable_o=1, tx_align_o=0, tx_rdy_o=1.
  - tx_locked_i=0 -> FAULT, code 4'h2.
  - else tx_underflow_i=1 -> FAULT, code 4'h3.
  - Lock loss has priority over underflow in the same cycle.
  - rx_rdy_i falling -> back to WAIT_PARTNER; tx_rdy_o drops and training resumes. Not a fault.
- FAULT:
  - tx_enable_o=0, tx_align_o=0, tx_rdy_o=0, tx_fault_fatal_o=1, code held.
  - Sticky until enable_i=0.
- enable_i=0 in any state -> DISABLED on the next edge, overriding all other conditions. Fault and code clear there.
- Outputs change one cycle after the deciding input edge: state register -> output register, 1-cycle latency.
- Error codes: 4'h0 none, 4'h1 lock timeout, 4'h2 lock lost, 4'h3 underflow, 4'h4 partner timeout; other values unused.
- Reset asserted mid-operation: immediate return to reset values, no partial state retained.

Optional Feature:
- Macro QECIPHY_TX_PARTNER_TIMEOUT_EN.
- Defined: in WAIT_PARTNER, counter reaching PARTNER_TIMEOUT_CYCLES-1 with rx_rdy_i=0 -> FAULT, code 4'h4. rx_rdy_i=1 on the timeout cycle wins.
- Undefined: WAIT_PARTNER waits indefinitely; code 4'h4 is never produced; PARTNER_TIMEOUT_CYCLES is ignored and excluded from counter width.

Test Plan:
- Nominal bring-up (LOCK_TIMEOUT_CYCLES=16, MIN_ALIGN_CYCLES=8):
  - stimulus: enable_i=1; tx_locked_i=1 at cycle 5; rx_rdy_i=1 at cycle 20.
  - response: tx_enable_o=1 from cycle 2; tx_align_o high until READY; tx_rdy_o=1 one cycle after rx_rdy_i is sampled; code 0.
- Lock timeout:
  - stimulus: enable_i=1, tx_locked_i held 0.
  - response: after 16 cycles in WAIT_LOCK, tx_fault_fatal_o=1, code 4'h1, tx_enable_o=0.
  - then: enable_i low 16 cycles -> all outputs 0; re-enable restarts at WAIT_LOCK.
- Lock loss during ALIGN and during READY:
  - stimulus: drop tx_locked_i for one cycle.
  - response: FAULT with code 4'h2; tx_rdy_o falls one cycle after the drop.
- Simultaneous lock loss and underflow in READY:
  - response: code 4'h2, not 4'h3. Underflow alone gives code 4'h3.
- rx_rdy_i drop in READY:
  - response: tx_rdy_o=0 and tx_align_o=1 next cycle, no fault; rx_rdy_i re-rise returns to READY.
- QECIPHY_TX_PARTNER_TIMEOUT_EN (PARTNER_TIMEOUT_CYCLES=32):
  - stimulus: rx_rdy_i held 0.
  - response with macro: FAULT, code 4'h4 after 32 cycles in WAIT_PARTNER.
  - response without macro: remains in WAIT_PARTNER for 1000 cycles with no fault.
